vedic16_seq_ctrl: RTL

Area-reduced 16×16 unsigned multiplier built from a single shared vedic8 core. It sequences the four 8×8 partial products (aL·bL, aH·bL, aL·bH, aH·bH) through the one core over four cycles and accumulates them into a 32-bit result. Operands are accepted and results returned over valid/ready handshakes. It sits beside vedic16 as the low-area alternative for designs that can tolerate multi-cycle latency.

---
 rtl/vedic_pkg.sv | 29 ++
 rtl/vedic4.sv | 17 +
 rtl/vedic8.sv | 18 +
 rtl/vedic16_seq_ctrl.sv | 108 ++++++++++
 4 files changed

// File: rtl/vedic_pkg.sv
// Shared types and step helpers for the sequential vedic multiplier.
package vedic_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int NUM_STEPS = 4;
  localparam int STEP_W    = 2;

  // Step encoding: bit0 picks the high half of a, bit1 the high half of b.
  // s=0 aL*bL, s=1 aH*bL, s=2 aL*bH, s=3 aH*bH.
  function automatic logic step_a_hi(input logic [STEP_W-1:0] s);
    return s[0];
  endfunction

  function automatic logic step_b_hi(input logic [STEP_W-1:0] s);
    return s[1];
  endfunction

  // Weight of each partial product: 0, W, W, 2W.
  function automatic int unsigned step_shift(input logic [STEP_W-1:0] s,
                                             input int unsigned core_w);
    return (32'(s[0]) + 32'(s[1])) * core_w;
  endfunction

endpackage

// File: rtl/vedic4.sv
// 4x4 unsigned vedic core: four 2x2 crosswise products summed by weight.
module vedic4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [7:0] p
);
  logic [3:0] pp_ll, pp_hl, pp_lh, pp_hh;

  // Vertical and crosswise 2x2 products, then weighted sum.
  always_comb begin
    pp_ll = {2'b0, a[1:0]} * {2'b0, b[1:0]};
    pp_hl = {2'b0, a[3:2]} * {2'b0, b[1:0]};
    pp_lh = {2'b0, a[1:0]} * {2'b0, b[3:2]};
    pp_hh = {2'b0, a[3:2]} * {2'b0, b[3:2]};
    p = {4'b0, pp_ll} + {2'b0, pp_hl, 2'b0} + {2'b0, pp_lh, 2'b0} + {pp_hh, 4'b0};
  end
endmodule

// File: rtl/vedic8.sv
// 8x8 unsigned vedic core built from four vedic4 blocks.
module vedic8 (
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic [15:0] p
);
  logic [7:0] q_ll, q_hl, q_lh, q_hh;

  vedic4 u_ll (.a(a[3:0]), .b(b[3:0]), .p(q_ll));
  vedic4 u_hl (.a(a[7:4]), .b(b[3:0]), .p(q_hl));
  vedic4 u_lh (.a(a[3:0]), .b(b[7:4]), .p(q_lh));
  vedic4 u_hh (.a(a[7:4]), .b(b[7:4]), .p(q_hh));

  // Weighted sum of the four 4x4 partial products.
  always_comb begin
    p = {8'b0, q_ll} + {4'b0, q_hl, 4'b0} + {4'b0, q_lh, 4'b0} + {q_hh, 8'b0};
  end
endmodule

// File: rtl/vedic16_seq_ctrl.sv
// Low-area 2W x 2W multiplier: one shared vedic core, four partial
// products accumulated over four cycles, valid/ready on both sides.
module vedic16_seq_ctrl
  import vedic_pkg::*;
#(
  parameter int CORE_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2*CORE_W-1:0]   a,
  input  logic [2*CORE_W-1:0]   b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*CORE_W-1:0]   p,
  output logic                  busy
);
  localparam int OP_W = 2 * CORE_W;
  localparam int P_W  = 4 * CORE_W;
  localparam int SH_W = $clog2(P_W);
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(NUM_STEPS - 1);

  state_t              state_q, state_d;
  logic [STEP_W-1:0]   s_q, s_d;
  logic [P_W-1:0]      acc_q, acc_d;
  logic [OP_W-1:0]     a_q, a_d, b_q, b_d;

  logic [CORE_W-1:0]   core_a, core_b;
  logic [OP_W-1:0]     core_p;
  logic [P_W-1:0]      core_ext;
  logic [SH_W-1:0]     sh;

  // Operand halves come only from the captured copies, so input changes
  // after acceptance cannot disturb a running product.
  always_comb begin
    core_a = step_a_hi(s_q) ? a_q[OP_W-1:CORE_W] : a_q[CORE_W-1:0];
    core_b = step_b_hi(s_q) ? b_q[OP_W-1:CORE_W] : b_q[CORE_W-1:0];
  end

  generate
    if (CORE_W == 8) begin : g_core8
      vedic8 u_core (.a(core_a), .b(core_b), .p(core_p));
    end else if (CORE_W == 4) begin : g_core4
      vedic4 u_core (.a(core_a), .b(core_b), .p(core_p));
    end else begin : g_core_bad
      $error("vedic16_seq_ctrl: CORE_W must be 4 or 8");
    end
  endgenerate

  // State, step counter, accumulator and captured operands.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      s_q     <= '0;
      acc_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      acc_q   <= acc_d;
      a_q     <= a_d;
      b_q     <= b_d;
    end
  end

  // Next state and datapath: capture on accept, one partial product per MUL cycle.
  always_comb begin
    state_d  = state_q;
    s_d      = s_q;
    acc_d    = acc_q;
    a_d      = a_q;
    b_d      = b_q;
    sh       = SH_W'(step_shift(s_q, CORE_W));
    core_ext = {{(P_W-OP_W){1'b0}}, core_p};
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          a_d     = a;
          b_d     = b;
          acc_d   = '0;
          s_d     = '0;
          state_d = MUL;
        end
      end
      MUL: begin
        // Full product fits in P_W bits, so the carry-out is dropped.
        acc_d = acc_q + (core_ext << sh);
        s_d   = s_q + 1'b1;
        if (s_q == LAST_STEP) state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs decode registered state; in_ready is also held low during reset.
  always_comb begin
    in_ready  = (state_q == IDLE) && !rst;
    out_valid = (state_q == DONE);
    busy      = (state_q != IDLE);
    p         = acc_q;
  end

endmodule
